sent_tx_frame_gen: RTL

- SENT transmit frame generator, directly downstream of the SENT TX data register.
- Consumes the assembled fast-channel words data_f1/data_f2 on their done_f1/done_f2 strobes and drives the fast-channel format select load_bit_f1/load_bit_f2 back to that stage.
- Builds SAE J2716 frames (sync, status, 6 data nibbles, CRC-4) and emits the tick-timed open-drain-style line waveform sent_out.

---
 rtl/sent_tx_frame_gen.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sent_tx_frame_gen.sv
// SENT (SAE J2716) transmit frame generator: sync, status, 6 data nibbles, CRC-4, tick-timed line.
// Optional pause symbol compiled in with `define SENT_PAUSE_EN.
module sent_tx_frame_gen #(
    parameter int TICK_DIV    = 3,
    parameter int LOW_TICKS   = 5,
    parameter int FRAME_TICKS = 282
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  fmt,
    input  logic [3:0]  status_nibble,
    input  logic [15:0] data_f1,
    input  logic [11:0] data_f2,
    input  logic        done_f1,
    input  logic        done_f2,
    output logic [1:0]  load_bit_f1,
    output logic [1:0]  load_bit_f2,
    output logic        sent_out,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC   = 3'd1;
    localparam logic [2:0] S_STATUS = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CRC    = 3'd4;
`ifdef SENT_PAUSE_EN
    localparam logic [2:0] S_PAUSE  = 3'd5;
`endif
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 1 || LOW_TICKS < 1 || LOW_TICKS >= 12 || FRAME_TICKS < 12) begin : g_cfg_err
        $error("sent_tx_frame_gen: unsupported parameter set");
    end

    // One CRC table lookup: multiply by x^4 modulo x^4+x^3+x^2+1.
    function automatic logic [3:0] crc_step(input logic [3:0] c);
        logic [3:0] v;
        v = c;
        for (int k = 0; k < 4; k++)
            v = {v[2:0], 1'b0} ^ (v[3] ? 4'hD : 4'h0);
        return v;
    endfunction

    logic [PW-1:0] r_presc;
    logic [2:0]    r_state;
    logic [2:0]    r_idx;
    logic [15:0]   r_tcnt;
    logic [3:0]    r_crc;
    logic [23:0]   r_vec;
    logic [3:0]    r_status;
    logic [15:0]   r_f1;
    logic [11:0]   r_f2;
    logic          r_pend_f1;
    logic          r_pend_f2;
    logic [1:0]    r_lb;
    logic          r_out;
    logic          r_fd;
    logic          r_ov;

    logic          w_tick;
    logic          w_start;
    logic          w_last;
    logic [1:0]    w_fmt;
    logic [23:0]   w_vec;
    logic [3:0]    w_nib;
    logic [3:0]    w_sym_nib;
    logic [15:0]   w_len;

    assign w_tick  = (r_presc == PW'(TICK_DIV - 1));
    assign w_fmt   = (fmt == 2'b00) ? 2'b01 : fmt;
    assign w_start = w_tick && (r_state == S_IDLE) && enable && r_pend_f1 && r_pend_f2;
    assign w_last  = (r_tcnt == w_len - 16'd1);

    always_ff @(posedge clk) begin
        if (reset)       r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // All three formats reduce to one 24-bit vector sent MSB nibble first.
    always_comb begin
        w_vec = {r_f1[11:0], r_f2};
        case (w_fmt)
            2'b11:   w_vec = {r_f1, r_f2[7:0]};
            2'b10:   w_vec = {r_f1[13:0], r_f2[9:0]};
            default: w_vec = {r_f1[11:0], r_f2};
        endcase
    end

    always_comb begin
        w_nib = 4'h0;
        case (r_idx)
            3'd0:    w_nib = r_vec[23:20];
            3'd1:    w_nib = r_vec[19:16];
            3'd2:    w_nib = r_vec[15:12];
            3'd3:    w_nib = r_vec[11:8];
            3'd4:    w_nib = r_vec[7:4];
            3'd5:    w_nib = r_vec[3:0];
            default: w_nib = 4'h0;
        endcase
    end

    always_comb begin
        w_sym_nib = 4'h0;
        case (r_state)
            S_STATUS: w_sym_nib = r_status;
            S_DATA:   w_sym_nib = w_nib;
            S_CRC:    w_sym_nib = r_crc;
            default:  w_sym_nib = 4'h0;
        endcase
    end

`ifdef SENT_PAUSE_EN
    logic [15:0] r_used;
    logic [15:0] r_plen;
    logic [15:0] w_used_next;
    logic [15:0] w_pause_len;

    assign w_used_next = r_used + w_len;
    assign w_pause_len = (32'(w_used_next) + 32'd12 > 32'(FRAME_TICKS)) ? 16'd12
                                                                        : 16'(FRAME_TICKS) - w_used_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_used <= '0;
            r_plen <= 16'd12;
        end else if (w_start) begin
            r_used <= '0;
        end else if (w_tick && r_state != S_IDLE && w_last) begin
            r_used <= w_used_next;
            if (r_state == S_CRC) r_plen <= w_pause_len;
        end
    end

    always_comb begin
        if (r_state == S_SYNC)       w_len = 16'd56;
        else if (r_state == S_PAUSE) w_len = r_plen;
        else                         w_len = 16'd12 + {12'd0, w_sym_nib};
    end
`else
    always_comb begin
        if (r_state == S_SYNC) w_len = 16'd56;
        else                   w_len = 16'd12 + {12'd0, w_sym_nib};
    end
`endif

    // Capture side; a strobe in the start cycle re-arms the flag for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_f1      <= '0;
            r_f2      <= '0;
            r_pend_f1 <= 1'b0;
            r_pend_f2 <= 1'b0;
            r_ov      <= 1'b0;
        end else begin
            // Data consumed by the starting frame is not lost, so no overrun then.
            r_ov <= (done_f1 && r_pend_f1 && !w_start) || (done_f2 && r_pend_f2 && !w_start);
            if (done_f1) begin
                r_f1      <= data_f1;
                r_pend_f1 <= 1'b1;
            end else if (w_start) begin
                r_pend_f1 <= 1'b0;
            end
            if (done_f2) begin
                r_f2      <= data_f2;
                r_pend_f2 <= 1'b1;
            end else if (w_start) begin
                r_pend_f2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_tcnt   <= '0;
            r_crc    <= 4'h5;
            r_vec    <= '0;
            r_status <= '0;
            r_lb     <= 2'b01;
            r_out    <= 1'b1;
            r_fd     <= 1'b0;
        end else begin
            r_fd <= 1'b0;
            if (r_state == S_IDLE) begin
                r_lb <= w_fmt;
                if (w_start) begin
                    r_vec    <= w_vec;
                    r_status <= status_nibble;
                    r_crc    <= 4'h5;
                    r_idx    <= '0;
                    r_tcnt   <= '0;
                    r_out    <= 1'b0;
                    r_state  <= S_SYNC;
                end
            end else if (w_tick) begin
                if (w_last) begin
                    r_tcnt <= '0;
                    r_out  <= 1'b0;
                    case (r_state)
                        S_SYNC:   r_state <= S_STATUS;
                        S_STATUS: begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end
                        S_DATA: begin
                            if (r_idx == 3'd5) begin
                                r_crc   <= crc_step(crc_step(r_crc) ^ w_nib);
                                r_state <= S_CRC;
                            end else begin
                                r_crc <= crc_step(r_crc) ^ w_nib;
                                r_idx <= r_idx + 3'd1;
                            end
                        end
`ifdef SENT_PAUSE_EN
                        S_CRC:    r_state <= S_PAUSE;
`endif
                        default: begin
                            r_state <= S_IDLE;
                            r_out   <= 1'b1;
                            r_fd    <= 1'b1;
                        end
                    endcase
                end else begin
                    r_tcnt <= r_tcnt + 16'd1;
                    if (r_tcnt + 16'd1 == 16'(LOW_TICKS)) r_out <= 1'b1;
                end
            end
        end
    end

    assign load_bit_f1 = r_lb;
    assign load_bit_f2 = r_lb;
    assign sent_out    = r_out;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_fd;
    assign overrun     = r_ov;

endmodule
